// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched -- shared iterative divide controller for the two issue lanes.
//
// Arbitrates DIV/DIVU requests from FU lanes 0/1 (lane 0 has fixed priority),
// runs one radix-2 restoring divider (one quotient bit per cycle), requests a
// pipeline stall while work is outstanding and returns quotient/remainder
// with the destination tag of the served request.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_flash             pipeline flush; aborts any operation
//   i_req_valid[1:0]    lane i has a divide op pending (held until served)
//   i_req_signed[1:0]   1 = DIV (signed), 0 = DIVU
//   i_req_num1/num2     dividend / divisor per lane
//   i_req_dst           destination tag per lane
//   o_grant[1:0]        one-hot, combinational: lane accepted this cycle
//   o_busy              controller not idle
//   o_stall_req         freeze issue/ex
//   o_done              one-cycle result-valid pulse
//   o_result_lane/_lo/_hi/_dst   lane, quotient, remainder, tag of last result
//   o_stall_cycles      stall_req-high cycle counter (DIV_SCHED_PERF_EN only,
//                       otherwise constant 0)
//
// Build option: define DIV_SCHED_PERF_EN to include the stall cycle counter.
// ---------------------------------------------------------------------------
module div_sched #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flash,
    input  logic [1:0]             i_req_valid,
    input  logic [1:0]             i_req_signed,
    input  logic [1:0][DATA_W-1:0] i_req_num1,
    input  logic [1:0][DATA_W-1:0] i_req_num2,
    input  logic [1:0][4:0]        i_req_dst,
    output logic [1:0]             o_grant,
    output logic                   o_busy,
    output logic                   o_stall_req,
    output logic                   o_done,
    output logic                   o_result_lane,
    output logic [DATA_W-1:0]      o_result_lo,
    output logic [DATA_W-1:0]      o_result_hi,
    output logic [4:0]             o_result_dst,
    output logic [31:0]            o_stall_cycles
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_served;
    logic [1:0]          w_served_nxt;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_div;
    logic                r_signed;
    logic                r_s1;
    logic                r_s2;
    logic                r_dz;
    logic [4:0]          r_dst;
    logic                r_lane;

    // Arbitration: pending = valid and not already served, lane 0 first.
    logic [1:0]          w_pend;
    logic                w_lane;
    logic                w_take;
    logic [DATA_W-1:0]   w_num1;
    logic [DATA_W-1:0]   w_num2;
    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_abs1;
    logic [DATA_W-1:0]   w_abs2;
    logic                w_dz;

    assign w_pend = i_req_valid & ~r_served;
    assign w_lane = ~w_pend[0];
    assign w_take = (r_state == S_IDLE) && (w_pend != 2'b00) && !i_flash;

    assign w_num1 = i_req_num1[w_lane];
    assign w_num2 = i_req_num2[w_lane];
    assign w_neg1 = i_req_signed[w_lane] & w_num1[DATA_W-1];
    assign w_neg2 = i_req_signed[w_lane] & w_num2[DATA_W-1];
    assign w_abs1 = w_neg1 ? (~w_num1 + DATA_W'(1)) : w_num1;
    assign w_abs2 = w_neg2 ? (~w_num2 + DATA_W'(1)) : w_num2;
    assign w_dz   = (w_num2 == '0);

    // Restoring step: the shifted partial remainder is DATA_W+1 bits wide;
    // its top bit set means the subtraction cannot borrow.
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W-1:0]   w_diff;
    logic                w_borrow;
    logic                w_no_borrow;
    logic [DATA_W-1:0]   w_rem_nxt;

    assign w_rem_sh                = {r_rem, r_quo[DATA_W-1]};
    assign {w_borrow, w_diff}      = {1'b0, w_rem_sh[DATA_W-1:0]} - {1'b0, r_div};
    assign w_no_borrow             = w_rem_sh[DATA_W] | ~w_borrow;
    assign w_rem_nxt               = w_no_borrow ? w_diff : w_rem_sh[DATA_W-1:0];

    // Sign fix-up; divide-by-zero results are returned raw.
    logic [DATA_W-1:0]   w_fix_lo;
    logic [DATA_W-1:0]   w_fix_hi;

    assign w_fix_lo = (r_signed && (r_s1 ^ r_s2) && !r_dz) ? (~r_quo + DATA_W'(1)) : r_quo;
    assign w_fix_hi = (r_signed && r_s1 && !r_dz)          ? (~r_rem + DATA_W'(1)) : r_rem;

    // Served flags: cleared when upstream drops the request or on flash.
    always_comb begin
        w_served_nxt = r_served & i_req_valid;
        if (w_take) begin
            w_served_nxt[w_lane] = 1'b1;
        end
        if (i_flash) begin
            w_served_nxt = 2'b00;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flash) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        w_state_nxt = w_dz ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_FIX;
                    end
                end
                S_FIX:   w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        o_grant     = 2'b00;
        o_busy      = 1'b0;
        o_stall_req = 1'b0;
        o_done      = 1'b0;
        if (w_take) begin
            o_grant = w_lane ? 2'b10 : 2'b01;
        end
        o_busy      = (r_state != S_IDLE);
        o_stall_req = (r_state == S_CALC) || (r_state == S_FIX) ||
                      ((w_pend != 2'b00) && (r_state != S_DONE));
        o_done      = (r_state == S_DONE) && !i_flash;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_served      <= 2'b00;
            r_cnt         <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            r_signed      <= 1'b0;
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_dz          <= 1'b0;
            r_dst         <= 5'd0;
            r_lane        <= 1'b0;
            o_result_lane <= 1'b0;
            o_result_lo   <= '0;
            o_result_hi   <= '0;
            o_result_dst  <= 5'd0;
        end else begin
            r_served <= w_served_nxt;

            if (i_flash || w_take) begin
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_take) begin
                r_quo    <= w_dz ? '1 : w_abs1;
                r_rem    <= w_dz ? w_num1 : '0;
                r_div    <= w_abs2;
                r_signed <= i_req_signed[w_lane];
                r_s1     <= w_neg1;
                r_s2     <= w_neg2;
                r_dz     <= w_dz;
                r_dst    <= i_req_dst[w_lane];
                r_lane   <= w_lane;
            end else if ((r_state == S_CALC) && !i_flash) begin
                r_rem <= w_rem_nxt;
                r_quo <= {r_quo[DATA_W-2:0], w_no_borrow};
            end

            if ((r_state == S_FIX) && !i_flash) begin
                o_result_lo   <= w_fix_lo;
                o_result_hi   <= w_fix_hi;
                o_result_dst  <= r_dst;
                o_result_lane <= r_lane;
            end
        end
    end

`ifdef DIV_SCHED_PERF_EN
    // Free-running stall cycle counter; only reset clears it.
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (o_stall_req) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched -- directed self-checking bench for div_sched.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_div_sched;

    localparam int unsigned DW = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flash;
    logic [1:0]          req_valid;
    logic [1:0]          req_signed;
    logic [1:0][DW-1:0]  req_num1;
    logic [1:0][DW-1:0]  req_num2;
    logic [1:0][4:0]     req_dst;
    logic [1:0]          grant;
    logic                busy;
    logic                stall_req;
    logic                done;
    logic                result_lane;
    logic [DW-1:0]       result_lo;
    logic [DW-1:0]       result_hi;
    logic [4:0]          result_dst;
    logic [31:0]         stall_cycles;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_sched #(.DATA_W(DW), .CNT_W(6)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flash        (flash),
        .i_req_valid    (req_valid),
        .i_req_signed   (req_signed),
        .i_req_num1     (req_num1),
        .i_req_num2     (req_num2),
        .i_req_dst      (req_dst),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_stall_req    (stall_req),
        .o_done         (done),
        .o_result_lane  (result_lane),
        .o_result_lo    (result_lo),
        .o_result_hi    (result_hi),
        .o_result_dst   (result_dst),
        .o_stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for done; counts stall_req-high cycles and cycles where
    // stall_req was low outside the done cycle.
    task automatic wait_done(input int max, output int lat, output int stalls, output int gaps);
        lat    = 0;
        stalls = 0;
        gaps   = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            #1;
            if (stall_req) stalls++;
            else if (!done) gaps++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input int lane, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                          input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        int stalls;
        int gaps;
        req_valid        = 2'b00;
        req_valid[lane]  = 1'b1;
        req_signed[lane] = sgn;
        req_num1[lane]   = a;
        req_num2[lane]   = b;
        req_dst[lane]    = dst;
        #1;
        chk({tag, " grant"}, 32'(grant), (lane == 1) ? 32'd2 : 32'd1);
        chk({tag, " stall_at_grant"}, 32'(stall_req), 32'd1);
        wait_done(60, lat, stalls, gaps);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall_count"}, 32'(stalls + 1), 32'(exp_lat));
        chk({tag, " grant_in_done"}, 32'(grant), 32'd0);
        chk({tag, " lo"}, result_lo, exp_lo);
        chk({tag, " hi"}, result_hi, exp_hi);
        chk({tag, " dst"}, 32'(result_dst), 32'(dst));
        chk({tag, " lane"}, 32'(result_lane), 32'(lane));
        req_valid = 2'b00;
        tick();
        #1;
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " done_pulse_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stalls;
        int gaps;
        int bad_done;

        rst_n      = 1'b0;
        flash      = 1'b0;
        req_valid  = 2'b00;
        req_signed = 2'b00;
        req_num1   = '0;
        req_num2   = '0;
        req_dst    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset stall", 32'(stall_req), 32'd0);
        chk("reset lo", result_lo, 32'd0);
        chk("reset hi", result_hi, 32'd0);
        chk("reset stall_cycles", stall_cycles, 32'd0);

        // Basic unsigned divide on lane 0.
        run_op("divu_100_7", 0, 1'b0, 32'd100, 32'd7, 5'd5, 34, 32'd14, 32'd2);
`ifdef DIV_SCHED_PERF_EN
        chk("perf single op", stall_cycles, 32'd34);
`else
        chk("perf disabled", stall_cycles, 32'd0);
`endif

        // Signed divides on both lanes, including the overflow corner.
        tick();
        run_op("div_m100_7", 1, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        tick();
        run_op("div_min_m1", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 34, 32'h8000_0000, 32'd0);
        tick();
        run_op("div_7_m2", 0, 1'b1, 32'd7, 32'hFFFF_FFFE, 5'd30, 34, 32'hFFFF_FFFD, 32'd1);

        // Divide by zero: fast path, raw remainder even when signed.
        tick();
        run_op("divu_by0", 1, 1'b0, 32'h0000_1234, 32'd0, 5'd3, 2, 32'hFFFF_FFFF, 32'h0000_1234);
        tick();
        run_op("div_by0_neg", 0, 1'b1, 32'hFFFF_FFFB, 32'd0, 5'd12, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Simultaneous requests: lane 0 first, lane 1 right after DONE.
        tick();
        req_valid  = 2'b11;
        req_signed = 2'b00;
        req_num1[0] = 32'd9;  req_num2[0] = 32'd3; req_dst[0] = 5'd1;
        req_num1[1] = 32'd8;  req_num2[1] = 32'd2; req_dst[1] = 5'd2;
        #1;
        chk("both grant0", 32'(grant), 32'd1);
        wait_done(60, lat, stalls, gaps);
        chk("both lat0", 32'(lat), 32'd34);
        chk("both stall_gaps0", 32'(gaps), 32'd0);
        chk("both lo0", result_lo, 32'd3);
        chk("both lane0", 32'(result_lane), 32'd0);
        chk("both no_grant_in_done", 32'(grant), 32'd0);
        req_valid[0] = 1'b0;
        tick();
        #1;
        chk("both grant1", 32'(grant), 32'd2);
        chk("both stall_grant1", 32'(stall_req), 32'd1);
        wait_done(60, lat, stalls, gaps);
        chk("both lat1", 32'(lat), 32'd34);
        chk("both stall_gaps1", 32'(gaps), 32'd0);
        chk("both lo1", result_lo, 32'd4);
        chk("both hi1", result_hi, 32'd0);
        chk("both dst1", 32'(result_dst), 32'd2);
        chk("both lane1", 32'(result_lane), 32'd1);
        req_valid = 2'b00;

        // Flash mid-CALC: abort, results kept, held request regranted.
        tick();
        req_valid  = 2'b01;
        req_signed = 2'b00;
        req_num1[0] = 32'd1000; req_num2[0] = 32'd10; req_dst[0] = 5'd7;
        #1;
        chk("flash grant", 32'(grant), 32'd1);
        bad_done = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            #1;
            if (done) bad_done++;
        end
        tick();
        flash = 1'b1;
        #1;
        chk("flash busy_before", 32'(busy), 32'd1);
        chk("flash grant_during", 32'(grant), 32'd0);
        chk("flash done_during", 32'(done | 1'(bad_done != 0)), 32'd0);
        tick();
        flash = 1'b0;
        #1;
        chk("flash busy_after", 32'(busy), 32'd0);
        chk("flash lo_kept", result_lo, 32'd4);
        chk("flash dst_kept", 32'(result_dst), 32'd2);
        chk("flash lane_kept", 32'(result_lane), 32'd1);
        chk("flash regrant", 32'(grant), 32'd1);
        wait_done(60, lat, stalls, gaps);
        chk("flash regrant_lat", 32'(lat), 32'd34);
        chk("flash regrant_lo", result_lo, 32'd100);
        chk("flash regrant_dst", 32'(result_dst), 32'd7);
        req_valid = 2'b00;

        // Flash in FIX: DONE pulse suppressed, results not loaded.
        tick();
        req_valid  = 2'b01;
        req_num1[0] = 32'd20; req_num2[0] = 32'd6; req_dst[0] = 5'd11;
        #1;
        chk("fixflash grant", 32'(grant), 32'd1);
        for (int k = 1; k <= 32; k++) tick();
        tick();
        flash     = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("fixflash busy_in_fix", 32'(busy), 32'd1);
        chk("fixflash done_in_fix", 32'(done), 32'd0);
        tick();
        flash = 1'b0;
        #1;
        chk("fixflash no_done", 32'(done), 32'd0);
        chk("fixflash busy", 32'(busy), 32'd0);
        chk("fixflash lo_kept", result_lo, 32'd100);
        chk("fixflash dst_kept", 32'(result_dst), 32'd7);

        // Reset mid-operation clears everything.
        tick();
        req_valid  = 2'b10;
        req_signed = 2'b10;
        req_num1[1] = 32'hFFFF_FFCE; req_num2[1] = 32'd3; req_dst[1] = 5'd4;
        #1;
        chk("rst_mid grant", 32'(grant), 32'd2);
        for (int k = 1; k <= 5; k++) tick();
        tick();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid done", 32'(done), 32'd0);
        chk("rst_mid lo", result_lo, 32'd0);
        chk("rst_mid hi", result_hi, 32'd0);
        chk("rst_mid dst", 32'(result_dst), 32'd0);
        chk("rst_mid stall_cycles", stall_cycles, 32'd0);

        // Same op after reset completes normally: -50 / 3 = -16 rem -2.
        run_op("div_m50_3", 1, 1'b1, 32'hFFFF_FFCE, 32'd3, 5'd4, 34, 32'hFFFF_FFF0, 32'hFFFF_FFFE);
`ifdef DIV_SCHED_PERF_EN
        chk("perf after reset", stall_cycles, 32'd34);
`else
        chk("perf disabled end", stall_cycles, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
